// File: rtl/pipe_lsu_store_buffer.sv
// MEM-stage load/store initiator with a posted-store FIFO in front of a single-port word RAM.
// Latency: store post 0 cycles, load hit 0 cycles (forwarded), load miss 1 stall cycle.
// Backpressure: o_mstall=1 on load miss (one cycle) or on store into a full buffer (retried next cycle).
//
// Ports:
//   i_clock, i_reset            clock; asynchronous active-high reset
//   i_mwmem, i_mrmem            store / load request from MEM stage (held while o_mstall=1)
//   i_malu, i_mb                byte address (word bits used) and store data
//   o_mmo, o_mstall             load data to WB and pipeline freeze (both combinational)
//   o_sb_empty                  store buffer holds no entries
//   o_dm_addr/_we/_wdata        RAM request; i_dm_rdata returns one cycle after a read issue
module pipe_lsu_store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_mwmem,
    input  logic              i_mrmem,
    input  logic [31:0]       i_malu,
    input  logic [31:0]       i_mb,
    output logic [31:0]       o_mmo,
    output logic              o_mstall,
    output logic              o_sb_empty,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic              o_dm_we,
    output logic [31:0]       o_dm_wdata,
    input  logic [31:0]       i_dm_rdata
);

    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
    logic [31:0]       r_sb_data [SB_DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;

    logic [ADDR_W-1:0] w_addr;
    logic              w_full;
    logic              w_hit;
    logic [31:0]       w_fwd_data;
    logic              w_enq;
    logic              w_deq;
    logic              w_drain_ok;

    assign w_addr     = i_malu[ADDR_W+1:2];
    assign w_full     = (r_count == (PW+1)'(SB_DEPTH));
    assign o_sb_empty = (r_count == '0);

    // Scan from oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (((PW+1)'(i) < r_count) && (r_sb_addr[r_head + PW'(i)] == w_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_sb_data[r_head + PW'(i)];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_mmo       = '0;
        o_mstall    = 1'b0;
        o_dm_addr   = '0;
        o_dm_we     = 1'b0;
        o_dm_wdata  = '0;
        w_enq       = 1'b0;
        w_deq       = 1'b0;
        w_drain_ok  = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_IDLE: begin
                    // A load wins over a simultaneous store.
                    if (i_mrmem) begin
                        if (w_hit) begin
                            o_mmo      = w_fwd_data;
                            w_drain_ok = 1'b1;
                        end else begin
                            o_mstall    = 1'b1;
                            o_dm_addr   = w_addr;
                            w_state_nxt = S_LOAD;
                        end
                    end else if (i_mwmem) begin
                        if (!w_full) begin
                            w_enq = 1'b1;
                        end else begin
                            // Free a slot now; the held store is accepted next cycle.
                            o_mstall   = 1'b1;
                            w_drain_ok = 1'b1;
                        end
                    end else begin
                        w_drain_ok = 1'b1;
                    end
                end
                S_LOAD: begin
                    // The stalled load completes here; its held request is not reissued.
                    o_mmo       = i_dm_rdata;
                    w_state_nxt = S_IDLE;
                    w_drain_ok  = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_drain_ok && (r_count != '0)) begin
                w_deq      = 1'b1;
                o_dm_we    = 1'b1;
                o_dm_addr  = r_sb_addr[r_head];
                o_dm_wdata = r_sb_data[r_head];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset; validity is carried by head/count.
    always_ff @(posedge i_clock) begin
        if (w_enq) begin
            r_sb_addr[r_tail] <= w_addr;
            r_sb_data[r_tail] <= i_mb;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset && (r_state == S_IDLE))
            assert (!(i_mrmem && i_mwmem))
            else $error("pipe_lsu_store_buffer: load and store requested together");
    end

endmodule
